avalon_pio_bank: RTL

- Parametrised memory-mapped PIO peripheral for the platform. It replaces the fixed 10-bit LEDR and SW exports with one generic bank.
- Generalised in width, with input synchronisation, per-bit debounce, edge capture and a maskable interrupt. Atomic set/clear access to the outputs is also provided.
- It is an Avalon-MM slave on the system interconnect. It drives board outputs such as LEDs and samples board inputs such as switches.

---
 rtl/avalon_pio_pkg.sv | 17 +
 rtl/avalon_pio_bank_if.sv | 22 ++
 rtl/pio_debounce.sv | 78 +++++++
 rtl/avalon_pio_bank.sv | 118 +++++++++++
 4 files changed

// File: rtl/avalon_pio_pkg.sv
// Shared constants for the Avalon-MM PIO bank: register map, edge modes, bus width.
package avalon_pio_pkg;

   localparam int DATA_W = 32;

   localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
   localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
   localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
   localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
   localparam logic [2:0] ADDR_OUT_SET  = 3'd4;
   localparam logic [2:0] ADDR_OUT_CLR  = 3'd5;

   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_BOTH    = 2;

endpackage

// File: rtl/avalon_pio_bank_if.sv
// Avalon-MM slave bus bundle for the PIO bank (no waitrequest, fixed read latency 1).
interface avalon_pio_bank_if;
   import avalon_pio_pkg::*;

   logic [2:0]        avs_address;
   logic              avs_read;
   logic              avs_write;
   logic [DATA_W-1:0] avs_writedata;
   logic [DATA_W-1:0] avs_readdata;
   logic              avs_readdatavalid;

   modport master (
      output avs_address, avs_read, avs_write, avs_writedata,
      input  avs_readdata, avs_readdatavalid
   );

   modport slave (
      input  avs_address, avs_read, avs_write, avs_writedata,
      output avs_readdata, avs_readdatavalid
   );

endinterface

// File: rtl/pio_debounce.sv
// One input bit: synchroniser chain, stability counter and debounced output flop.
module pio_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   deb_q, deb_d;
   logic                   sync_bit;

   // Shift the asynchronous input through the synchroniser chain.
   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], din};
      sync_bit = sync_q[SYNC_STAGES-1];
   end

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         // Debounce disabled: the debounced flop simply follows the synchroniser.
         always_comb begin
            deb_d = sync_bit;
         end
      end else begin : g_filter
         localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
         localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

         logic             last_q, last_d;
         logic [CNT_W-1:0] cnt_q, cnt_d;

         // Count consecutive equal samples; accept the value once the run reaches CNT_MAX.
         always_comb begin
            last_d = sync_bit;
            if (sync_bit != last_q) begin
               cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               cnt_d = cnt_q;
            end
            if (cnt_d == CNT_MAX) begin
               deb_d = sync_bit;
            end else begin
               deb_d = deb_q;
            end
         end

         // Counter and last-sample state.
         always_ff @(posedge clk) begin
            if (rst) begin
               last_q <= 1'b0;
               cnt_q  <= '0;
            end else begin
               last_q <= last_d;
               cnt_q  <= cnt_d;
            end
         end
      end
   endgenerate

   // Synchroniser and debounced output state.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         deb_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         deb_q  <= deb_d;
      end
   end

   assign dout = deb_q;

endmodule

// File: rtl/avalon_pio_bank.sv
// Generic Avalon-MM PIO bank: output register with set/clear, debounced inputs,
// sticky edge capture and a maskable level interrupt.
module avalon_pio_bank
   import avalon_pio_pkg::*;
#(
   parameter int                   OUT_WIDTH       = 10,
   parameter int                   IN_WIDTH        = 10,
   parameter logic [OUT_WIDTH-1:0] OUT_RESET       = '0,
   parameter int                   SYNC_STAGES     = 2,
   parameter int                   DEBOUNCE_CYCLES = 0,
   parameter int                   EDGE_MODE       = 2
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset,
   avalon_pio_bank_if.slave     avs,
   output logic                 irq,
   output logic [OUT_WIDTH-1:0] ledr_export,
   input  logic [IN_WIDTH-1:0]  sw_export
);

   logic [IN_WIDTH-1:0]  data_in;
   logic [IN_WIDTH-1:0]  edge_hit;
   logic [OUT_WIDTH-1:0] out_q, out_d;
   logic [IN_WIDTH-1:0]  mask_q, mask_d;
   logic [IN_WIDTH-1:0]  cap_q, cap_d;
   logic [IN_WIDTH-1:0]  prev_q, prev_d;
   logic [DATA_W-1:0]    rdata_q, rdata_d;
   logic                 rvalid_q, rvalid_d;
   logic                 irq_q, irq_d;

   generate
      for (genvar i = 0; i < IN_WIDTH; i++) begin : g_in
         pio_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_deb (
            .clk  (clk_clk),
            .rst  (reset_reset),
            .din  (sw_export[i]),
            .dout (data_in[i])
         );
      end
   endgenerate

   // Edge detection on the debounced inputs against their previous value.
   always_comb begin
      prev_d = data_in;
      case (EDGE_MODE)
         EDGE_RISING:  edge_hit = data_in & ~prev_q;
         EDGE_FALLING: edge_hit = ~data_in & prev_q;
         default:      edge_hit = data_in ^ prev_q;
      endcase
   end

   // Register writes; a new edge overrides a same-cycle write-1-to-clear.
   always_comb begin
      out_d  = out_q;
      mask_d = mask_q;
      cap_d  = cap_q | edge_hit;
      if (avs.avs_write) begin
         case (avs.avs_address)
            ADDR_DATA_OUT: out_d  = avs.avs_writedata[OUT_WIDTH-1:0];
            ADDR_IRQ_MASK: mask_d = avs.avs_writedata[IN_WIDTH-1:0];
            ADDR_EDGE_CAP: cap_d  = (cap_q & ~avs.avs_writedata[IN_WIDTH-1:0]) | edge_hit;
            ADDR_OUT_SET:  out_d  = out_q | avs.avs_writedata[OUT_WIDTH-1:0];
            ADDR_OUT_CLR:  out_d  = out_q & ~avs.avs_writedata[OUT_WIDTH-1:0];
            default:       out_d  = out_q;
         endcase
      end else begin
         out_d = out_q;
      end
   end

   // Read mux samples pre-write state; readdata holds between reads.
   always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = avs.avs_read;
      irq_d    = |(cap_q & mask_q);
      if (avs.avs_read) begin
         case (avs.avs_address)
            ADDR_DATA_IN:  rdata_d = DATA_W'(data_in);
            ADDR_DATA_OUT: rdata_d = DATA_W'(out_q);
            ADDR_IRQ_MASK: rdata_d = DATA_W'(mask_q);
            ADDR_EDGE_CAP: rdata_d = DATA_W'(cap_q);
            default:       rdata_d = '0;
         endcase
      end else begin
         rdata_d = rdata_q;
      end
   end

   // Bank state; reset discards any same-cycle access.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         out_q    <= OUT_RESET;
         mask_q   <= '0;
         cap_q    <= '0;
         prev_q   <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         out_q    <= out_d;
         mask_q   <= mask_d;
         cap_q    <= cap_d;
         prev_q   <= prev_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         irq_q    <= irq_d;
      end
   end

   assign ledr_export           = out_q;
   assign irq                   = irq_q;
   assign avs.avs_readdata      = rdata_q;
   assign avs.avs_readdatavalid = rvalid_q;

endmodule
